// File: rtl/sigma_delta_spi_responder.sv
// Sigma-delta SPI responder: RDY low on sdo after bus idle, 8-bit command, result shifted out MSB-first; sdo lags sclk fall by ~3 clk.
// conv_ready drops only while result bits shift out; optional trailing CRC-8 byte under macro SIGMA_DELTA_RESPONDER_CRC_EN.
module sigma_delta_spi_responder #(
  parameter int         DATA_WIDTH    = 24,
  parameter logic [7:0] CMD_READ_DATA = 8'h58,
  parameter int         RDY_DELAY     = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  sdi,
  output logic                  sdo,
  input  logic                  conv_valid,
  input  logic [DATA_WIDTH-1:0] conv_data,
  output logic                  conv_ready,
  output logic                  overrun
);

`ifdef SIGMA_DELTA_RESPONDER_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int SH_W = DATA_WIDTH + CRC_BITS;
  localparam int CW   = $clog2(RDY_DELAY + 1);
  localparam logic [5:0]    LAST_BIT = 6'(SH_W - 1);
  localparam logic [CW-1:0] RDY_LAST = CW'(RDY_DELAY - 1);

  typedef enum logic [2:0] {IDLE, RDY_WAIT, RDY, CMD, DATA, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]            sclk_s, cs_s, sdi_s;
  logic                  sclk_q;
  logic                  sclk_rise, sclk_fall, sclk_edge, cs_hi, sdi_b;
  logic [CW-1:0]         rdy_cnt;
  logic [5:0]            bit_cnt;
  logic [6:0]            cmd_sh;
  logic [7:0]            cmd_byte;
  logic [DATA_WIDTH-1:0] result;
  logic                  pending, fresh, ready_en;
  logic [SH_W-1:0]       sh, sh_load;
  logic                  acc, data_last, crc_phase, enter_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_s <= 2'b11;
      cs_s   <= 2'b11;
      sdi_s  <= 2'b00;
      sclk_q <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[0], sclk};
      cs_s   <= {cs_s[0], cs};
      sdi_s  <= {sdi_s[0], sdi};
      sclk_q <= sclk_s[1];
    end
  end

  assign sclk_rise = !sclk_q && sclk_s[1];
  assign sclk_fall = sclk_q && !sclk_s[1];
  assign sclk_edge = sclk_rise || sclk_fall;
  assign cs_hi     = cs_s[1];
  assign sdi_b     = sdi_s[1];
  assign cmd_byte  = {cmd_sh, sdi_b};

`ifdef SIGMA_DELTA_RESPONDER_CRC_EN
  function automatic logic [7:0] crc8(input logic [DATA_WIDTH-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
  assign sh_load   = {result, crc8(result)};
  assign crc_phase = (bit_cnt >= 6'(DATA_WIDTH));
`else
  assign sh_load   = result;
  assign crc_phase = 1'b0;
`endif

  assign conv_ready = ready_en && ((state != DATA) || crc_phase);
  assign acc        = conv_valid && conv_ready;
  assign data_last  = (state == DATA) && !cs_hi && sclk_rise && (bit_cnt == LAST_BIT);
  assign enter_data = (state_nxt == DATA) && (state != DATA);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pending && !cs_hi) state_nxt = RDY_WAIT;
      RDY_WAIT: if (cs_hi) state_nxt = IDLE;
                else if (!sclk_edge && rdy_cnt == RDY_LAST) state_nxt = RDY;
      RDY:      if (cs_hi) state_nxt = IDLE;
                else if (sclk_fall) state_nxt = CMD;
      CMD:      if (cs_hi) state_nxt = IDLE;
                else if (sclk_rise && bit_cnt == 6'd7)
                  state_nxt = (cmd_byte == CMD_READ_DATA) ? DATA : DONE;
      DATA:     if (cs_hi) state_nxt = IDLE;
                else if (data_last) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      rdy_cnt <= '0;
      bit_cnt <= '0;
      cmd_sh  <= '0;
      sh      <= '0;
      sdo     <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state != RDY_WAIT || sclk_edge) rdy_cnt <= '0;
      else                                rdy_cnt <= rdy_cnt + 1'b1;
      if (state_nxt != state) bit_cnt <= '0;
      else if (sclk_rise && (state == CMD || state == DATA)) bit_cnt <= bit_cnt + 1'b1;
      if (state == CMD && sclk_rise) cmd_sh <= cmd_byte[6:0];
      // sdo only moves on a state change or a falling edge while shifting
      if (state_nxt != state)              sdo <= (state_nxt != RDY);
      else if (state == DATA && sclk_fall) sdo <= sh[SH_W-1];
      if (enter_data)                      sh <= sh_load;
      else if (state == DATA && sclk_fall) sh <= {sh[SH_W-2:0], 1'b0};
    end
  end

  // fresh marks a result accepted after the shift copy was taken, so the read must not clear it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result   <= '0;
      pending  <= 1'b0;
      fresh    <= 1'b0;
      overrun  <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      overrun  <= acc && pending;
      if (acc) begin
        result  <= conv_data;
        pending <= 1'b1;
      end else if (data_last && !fresh) begin
        pending <= 1'b0;
      end
      if (enter_data) fresh <= acc;
      else if (acc)   fresh <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sigma_delta_spi_responder.sv
// Randomised bench for sigma_delta_spi_responder: a host-side SPI driver plus a pending/result reference model.
module tb_sigma_delta_spi_responder;
  localparam int DW = 24;
`ifdef SIGMA_DELTA_RESPONDER_CRC_EN
  localparam int CRCB = 8;
`else
  localparam int CRCB = 0;
`endif
  localparam int RB   = DW + CRCB;
  localparam int HALF = 100;
  localparam logic [7:0] RD_CMD = 8'h58;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sclk = 1'b1;
  logic          cs = 1'b1;
  logic          sdi = 1'b0;
  logic          conv_valid = 1'b0;
  logic [DW-1:0] conv_data = '0;
  logic          sdo, conv_ready, overrun;

  int            n_checks = 0;
  int            n_pass = 0;
  int            ov_cnt = 0;
  bit            m_pending = 1'b0;
  logic [DW-1:0] m_result = '0;
  int            m_ovr = 0;

  always #5 clk = ~clk;

  sigma_delta_spi_responder #(.DATA_WIDTH(DW), .CMD_READ_DATA(RD_CMD), .RDY_DELAY(16)) dut (
    .clk(clk), .resetn(resetn), .sclk(sclk), .cs(cs), .sdi(sdi), .sdo(sdo),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_ready(conv_ready), .overrun(overrun)
  );

  always @(negedge clk) if (overrun) ov_cnt++;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

`ifdef SIGMA_DELTA_RESPONDER_CRC_EN
  // CRC as the remainder of polynomial long division of data*x^8 by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [DW-1:0] d);
    logic [DW+7:0] r;
    r = {d, 8'h00};
    for (int i = DW + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction
`endif

  task automatic accept(input logic [DW-1:0] d);
    @(negedge clk);
    check_eq("accept_ready", conv_ready, 1);
    conv_valid = 1'b1;
    conv_data  = d;
    @(negedge clk);
    conv_valid = 1'b0;
    if (m_pending) m_ovr++;
    m_pending = 1'b1;
    m_result  = d;
  endtask

  task automatic wait_rdy(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sdo == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic spi_cmd(input logic [7:0] cmd, output bit allone);
    allone = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0;
      sdi  = cmd[i];
      #(HALF);
      if (sdo !== 1'b1) allone = 1'b0;
      sclk = 1'b1;
      #(HALF);
    end
  endtask

  task automatic spi_read(input int nbits, output logic [39:0] rd, output logic cr);
    rd = '0;
    cr = 1'bx;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      #(HALF);
      rd = {rd[38:0], sdo};
      if (i == 5) cr = conv_ready;
      sclk = 1'b1;
      #(HALF);
    end
  endtask

  task automatic host_txn(input logic [7:0] cmd, input string tag);
    logic [39:0] rd;
    logic        cr;
    bit          seen, allone;
    @(negedge clk);
    cs = 1'b0;
    wait_rdy(60, seen);
    check_eq({tag, "_rdy"}, seen, m_pending);
    if (seen) begin
      spi_cmd(cmd, allone);
      check_eq({tag, "_cmd_sdo"}, allone, 1);
      if (cmd == RD_CMD) begin
        spi_read(RB, rd, cr);
        check_eq({tag, "_data"}, rd[RB-1 -: DW], m_result);
`ifdef SIGMA_DELTA_RESPONDER_CRC_EN
        check_eq({tag, "_crc"}, rd[7:0], crc_ref(m_result));
`endif
        check_eq({tag, "_ready_in_data"}, cr, 0);
        m_pending = 1'b0;
      end else begin
        spi_read(DW, rd, cr);
        check_eq({tag, "_sdo_high"}, rd[DW-1:0], {DW{1'b1}});
        check_eq({tag, "_ready_other"}, cr, 1);
      end
      check_eq({tag, "_sdo_after"}, sdo, 1);
    end
    wait_rdy(40, seen);
    check_eq({tag, "_rdy_after"}, seen, m_pending);
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0]   rd;
    logic          cr;
    logic [DW-1:0] w;
    logic [7:0]    cmd;
    bit            seen, allone;
    int            ov0, na;

    #23;
    check_eq("rst_sdo", sdo, 1);
    check_eq("rst_ready", conv_ready, 0);
    check_eq("rst_overrun", overrun, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", conv_ready, 1);

    @(negedge clk);
    cs = 1'b0;
    wait_rdy(40, seen);
    check_eq("no_rdy_empty", seen, 0);
    cs = 1'b1;
    repeat (4) @(negedge clk);

    accept(24'hA5C3F0);
    host_txn(RD_CMD, "read_a5c3f0");

    accept(24'h123456);
    host_txn(8'h3C, "cmd_3c");
    host_txn(RD_CMD, "read_after_3c");

    ov0 = ov_cnt;
    accept(24'h000001);
    accept(24'h000002);
    @(negedge clk);
    #1;
    check_eq("overrun_once", ov_cnt - ov0, 1);
    host_txn(RD_CMD, "read_overrun");

    // abort after 10 data bits with the 10th bit low so the recovery to 1 is visible
    w = DW'($urandom);
    w[DW-10] = 1'b0;
    accept(w);
    @(negedge clk);
    cs = 1'b0;
    wait_rdy(60, seen);
    check_eq("abort_rdy", seen, 1);
    spi_cmd(RD_CMD, allone);
    check_eq("abort_cmd_sdo", allone, 1);
    spi_read(10, rd, cr);
    check_eq("abort_partial", rd[9:0], w[DW-1 -: 10]);
    cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_sdo", sdo, 1);
    repeat (4) @(negedge clk);
    host_txn(RD_CMD, "read_after_abort");

    // reset in the middle of DATA while sdo is low
    w = DW'($urandom);
    w[DW-5] = 1'b0;
    accept(w);
    @(negedge clk);
    cs = 1'b0;
    wait_rdy(60, seen);
    check_eq("rstmid_rdy", seen, 1);
    spi_cmd(RD_CMD, allone);
    spi_read(5, rd, cr);
    check_eq("rstmid_pre_sdo", sdo, 0);
    #3;
    resetn = 1'b0;
    #1;
    check_eq("rstmid_sdo", sdo, 1);
    check_eq("rstmid_ready", conv_ready, 0);
    m_pending = 1'b0;
    cs = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("rstmid_ready_after", conv_ready, 1);
    cs = 1'b0;
    wait_rdy(40, seen);
    check_eq("rstmid_no_rdy", seen, 0);
    cs = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      na = $urandom_range(1, 2);
      for (int j = 0; j < na; j++) accept(DW'($urandom));
      if ($urandom_range(0, 1) == 1) cmd = RD_CMD;
      else begin
        cmd = 8'($urandom);
        if (cmd == RD_CMD) cmd = 8'hA7;
      end
      host_txn(cmd, "rand");
    end

`ifdef SIGMA_DELTA_RESPONDER_CRC_EN
    accept(24'h000000);
    host_txn(RD_CMD, "crc_zero");
    accept(24'h800000);
    host_txn(RD_CMD, "crc_800000");
`endif

    @(negedge clk);
    #1;
    check_eq("overrun_total", ov_cnt, m_ovr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
